prog_loader: RTL and testbench
==============================

# prog_loader

Program loader for the accumulator CPU's 32 × 8 instruction memory. It accepts a framed byte stream over a valid/ready handshake and writes the payload into instruction memory starting at address 0. It holds the CPU in reset until a frame with a valid checksum has been loaded. It is the write side of the instruction store that the CPU fetches from at `curr_pc`.

## Interface
Parameters:
- `DEPTH`, 32: instruction memory entries; maximum frame length.
- `ADDR_W`, 5: memory address width; matches the 5-bit PC.
- `TIMEOUT`, 1000: idle cycles allowed between bytes inside a frame; range 1..65535.

Ports:
- `clk_i` input 1: single clock; all state changes on the rising edge.
- `rst_i` input 1: reset, asynchronous, active-high.
- `rx_data_i` input 8: incoming byte.
- `rx_valid_i` input 1: `rx_data_i` is valid.
- `rx_ready_o` output 1: loader can accept a byte.
- `mem_we_o` output 1: instruction memory write enable, one-cycle pulse.
- `mem_addr_o` output ADDR_W: write address.
- `mem_data_o` output 8: write data.
- `cpu_rst_o` output 1: hold-reset to the CPU; 1 = CPU held.
- `busy_o` output 1: a frame is in progress.
- `done_o` output 1: one-cycle pulse when a frame loads successfully.
- `err_o` output 1: sticky error flag.

## Operation
- Frame format: sync byte 0xA5, length byte N (1..DEPTH), N payload bytes, checksum byte C.
  - The frame is valid when (sum of payload bytes + C) mod 256 = 0.
  - The running sum is 8 bits and wraps.
- A byte is accepted on a rising edge where `rx_valid_i & rx_ready_o` = 1.
  - `rx_ready_o` = 1 whenever reset is not asserted.
- State machine:
  - IDLE: accepted 0xA5 goes to LEN; it clears `err_o`, sets `cpu_rst_o` = 1 and `busy_o` = 1, and clears the index and sum. Any other byte is accepted and discarded.
  - LEN: N = 0 or N > DEPTH goes to IDLE with `err_o` = 1. Otherwise N is latched and the FSM goes to DATA.
  - DATA: each accepted byte is written at address = index, then index increments and sum += byte. After the N-th byte the FSM goes to CSUM.
  - CSUM: if sum + C = 0 mod 256, pulse `done_o`, set `cpu_rst_o` = 0, go to IDLE. Otherwise set `err_o` = 1, keep `cpu_rst_o` = 1, go to IDLE.
- Timeout: in LEN, DATA and CSUM a 16-bit counter counts cycles with no accepted byte.
  - When the counter reaches TIMEOUT: `err_o` = 1, go to IDLE, `cpu_rst_o` stays 1.
  - The counter clears on every accepted byte.
- 0xA5 received inside a frame is treated as ordinary length, payload or checksum data. It does not resynchronise the FSM.
- Memory contents written before an error are not rolled back. The CPU stays in reset, so it never runs partial code.
- A new frame after a successful load re-asserts `cpu_rst_o` and overwrites memory from address 0.

## Timing
- Reset values: `rx_ready_o` = 0, `mem_we_o` = 0, `mem_addr_o` = 0, `mem_data_o` = 0, `cpu_rst_o` = 1, `busy_o` = 0, `done_o` = 0, `err_o` = 0. FSM in IDLE, counters 0.
- All outputs are registered.
- Write latency: `mem_we_o`, `mem_addr_o` and `mem_data_o` are valid for exactly the one cycle after the payload byte is accepted.
- `done_o`, the `cpu_rst_o` fall and the `busy_o` fall all occur in the cycle after the checksum byte is accepted.
- `err_o` rises in the cycle after the offending byte, or in the cycle after the timeout is reached.
- `cpu_rst_o` and `busy_o` rise in the cycle after the sync byte is accepted.
- Back-to-back bytes, one per cycle, are sustained with no bubbles.
- Last payload address is N−1. N = DEPTH ends at address 31; the address never wraps.
- A byte accepted in the same cycle the timeout would be reached: the byte wins and the counter clears.
- `rst_i` mid-frame: immediate return to reset values. `cpu_rst_o` = 1, and no further writes occur.

## Test plan
- Frame A5 03 11 22 33 9A.
  - Required: writes (0,11), (1,22), (2,33) on consecutive cycles.
  - Required: `done_o` pulse one cycle after 9A, `cpu_rst_o` 1→0, `err_o` = 0.
- Same frame with checksum 9B.
  - Required: three writes occur, `err_o` = 1, `cpu_rst_o` stays 1, no `done_o`.
  - Then a correct frame: `err_o` clears on its sync byte and the load completes.
- Length 00, and separately length 21.
  - Required: `err_o` = 1 after the length byte, no writes, FSM in IDLE.
  - Required: a following 0xA5 is accepted as a sync byte.
- Full frame of 32 bytes, values 00..1F, checksum 10.
  - Required: 32 writes, addresses 0..31, then `done_o`.
- A5 02 11, then `rx_valid_i` = 0 for 1000 cycles.
  - Required: `err_o` = 1 exactly TIMEOUT cycles after the last accepted byte.
  - Required: with a byte arriving at cycle 999, no error occurs.
- Assert `rst_i` mid-payload.
  - Required: outputs return to reset values asynchronously and no `mem_we_o` pulse follows.
  - Required: a subsequent full frame loads correctly.

Source files
------------

// File: rtl/prog_loader.sv
// Loads a framed byte stream (A5, N, N payload bytes, checksum) into instruction memory and holds the CPU in reset until a frame checks good.
// Every output is registered. One byte can be accepted per cycle, and ready stays high whenever reset is not asserted.
module prog_loader #(
   parameter int DEPTH   = 32,
   parameter int ADDR_W  = 5,
   parameter int TIMEOUT = 1000
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [7:0]        rx_data_i,
   input  logic              rx_valid_i,
   output logic              rx_ready_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [7:0]        mem_data_o,
   output logic              cpu_rst_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   typedef enum logic [1:0] {S_IDLE, S_LEN, S_DATA, S_CSUM} state_t;

   localparam logic [8:0]  LP_DEPTH = 9'(DEPTH);
   localparam logic [15:0] LP_TO_M1 = 16'(TIMEOUT - 1);

   state_t            r_state;
   logic              r_rdy;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [7:0]        r_data;
   logic              r_cpu_rst;
   logic              r_busy;
   logic              r_done;
   logic              r_err;
   logic [ADDR_W:0]   r_len;
   logic [ADDR_W:0]   r_idx;
   logic [7:0]        r_sum;
   logic [15:0]       r_cnt;

   logic              w_acc;
   logic [ADDR_W:0]   w_idx_nxt;
   logic [7:0]        w_csum;
   logic              w_len_bad;

   assign w_acc     = rx_valid_i & r_rdy;
   assign w_idx_nxt = r_idx + {{ADDR_W{1'b0}}, 1'b1};
   assign w_csum    = r_sum + rx_data_i;
   assign w_len_bad = (rx_data_i == 8'h00) || ({1'b0, rx_data_i} > LP_DEPTH);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= S_IDLE;
         r_rdy     <= 1'b0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_data    <= '0;
         r_cpu_rst <= 1'b1;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_len     <= '0;
         r_idx     <= '0;
         r_sum     <= '0;
         r_cnt     <= '0;
      end else begin
         r_rdy  <= 1'b1;
         r_we   <= 1'b0;
         r_done <= 1'b0;
         if (r_state == S_IDLE) begin
            if (w_acc && rx_data_i == 8'hA5) begin
               r_state   <= S_LEN;
               r_err     <= 1'b0;
               r_cpu_rst <= 1'b1;
               r_busy    <= 1'b1;
               r_idx     <= '0;
               r_sum     <= '0;
               r_cnt     <= '0;
            end
         end else if (w_acc) begin
            // An accepted byte always beats the timeout, even on the cycle it would fire.
            r_cnt <= '0;
            case (r_state)
               S_LEN: begin
                  if (w_len_bad) begin
                     r_err   <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= S_IDLE;
                  end else begin
                     r_len   <= rx_data_i[ADDR_W:0];
                     r_state <= S_DATA;
                  end
               end
               S_DATA: begin
                  r_we   <= 1'b1;
                  r_addr <= r_idx[ADDR_W-1:0];
                  r_data <= rx_data_i;
                  r_sum  <= w_csum;
                  r_idx  <= w_idx_nxt;
                  if (w_idx_nxt == r_len) r_state <= S_CSUM;
               end
               S_CSUM: begin
                  if (w_csum == 8'h00) begin
                     r_done    <= 1'b1;
                     r_cpu_rst <= 1'b0;
                  end else begin
                     r_err <= 1'b1;
                  end
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
               default: ;
            endcase
         end else if (r_cnt == LP_TO_M1) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
         end else begin
            r_cnt <= r_cnt + 16'd1;
         end
      end
   end

   assign rx_ready_o = r_rdy;
   assign mem_we_o   = r_we;
   assign mem_addr_o = r_addr;
   assign mem_data_o = r_data;
   assign cpu_rst_o  = r_cpu_rst;
   assign busy_o     = r_busy;
   assign done_o     = r_done;
   assign err_o      = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: a frame-position reference model, checked against the DUT every cycle, plus directed literal checks.
module tb_prog_loader;
   localparam int TO = 1000;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready_o, mem_we_o, cpu_rst_o, busy_o, done_o, err_o;
   logic [4:0] mem_addr_o;
   logic [7:0] mem_data_o;

   always #5 clk = ~clk;

   prog_loader #(.DEPTH(32), .ADDR_W(5), .TIMEOUT(TO)) dut (
      .clk_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
      .rx_ready_o(rx_ready_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_data_o(mem_data_o), .cpu_rst_o(cpu_rst_o), .busy_o(busy_o),
      .done_o(done_o), .err_o(err_o));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pos 0 = hunting for sync, 1 = length, 2..n+1 = payload, n+2 = checksum.
   int         pos, n, idle_cnt;
   logic [7:0] pay [32];
   logic       m_rdy, e_we, e_cpu, e_busy, e_done, e_err;
   logic [4:0] e_addr;
   logic [7:0] e_data;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         pos = 0; n = 0; idle_cnt = 0;
         m_rdy = 0; e_we = 0; e_addr = 0; e_data = 0;
         e_cpu = 1; e_busy = 0; e_done = 0; e_err = 0;
      end else begin
         logic acc;
         acc = m_rdy && rx_valid;
         e_we = 0; e_done = 0;
         if (pos == 0) begin
            if (acc && rx_data == 8'hA5) begin
               pos = 1; e_err = 0; e_cpu = 1; e_busy = 1; idle_cnt = 0;
            end
         end else if (acc) begin
            idle_cnt = 0;
            if (pos == 1) begin
               if (rx_data == 0 || rx_data > 32) begin
                  e_err = 1; e_busy = 0; pos = 0;
               end else begin
                  n = int'(rx_data); pos = 2;
               end
            end else if (pos <= n + 1) begin
               pay[pos-2] = rx_data;
               e_we = 1; e_addr = 5'(pos - 2); e_data = rx_data;
               pos++;
            end else begin
               int s;
               s = int'(rx_data);
               for (int i = 0; i < n; i++) s += int'(pay[i]);
               if (s % 256 == 0) begin
                  e_done = 1; e_cpu = 0;
               end else begin
                  e_err = 1;
               end
               e_busy = 0; pos = 0;
            end
         end else begin
            idle_cnt++;
            if (idle_cnt == TO) begin
               e_err = 1; e_busy = 0; pos = 0; idle_cnt = 0;
            end
         end
         m_rdy = 1;
      end
   end

   always @(negedge clk) begin
      check("rx_ready", 32'(rx_ready_o), 32'(m_rdy));
      check("mem_we",   32'(mem_we_o),   32'(e_we));
      check("cpu_rst",  32'(cpu_rst_o),  32'(e_cpu));
      check("busy",     32'(busy_o),     32'(e_busy));
      check("done",     32'(done_o),     32'(e_done));
      check("err",      32'(err_o),      32'(e_err));
      if (e_we) begin
         check("mem_addr", 32'(mem_addr_o), 32'(e_addr));
         check("mem_data", 32'(mem_data_o), 32'(e_data));
      end
   end

   // Observation log used by the directed literal checks.
   logic [7:0] shadow [32];
   int wr_cnt = 0, done_cnt = 0, cyc = 0, last_acc = 0, err_rise = 0;
   logic err_q = 1'b0;

   always @(posedge clk) begin
      cyc++;
      if (rx_valid && rx_ready_o) last_acc = cyc;
   end

   always @(negedge clk) begin
      if (mem_we_o) begin
         shadow[mem_addr_o] = mem_data_o;
         wr_cnt++;
      end
      if (done_o) done_cnt++;
      if (err_o && !err_q) err_rise = cyc;
      err_q = err_o;
   end

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
   endtask

   task automatic idle(input int k);
      repeat (k) begin
         @(negedge clk);
         rx_valid = 1'b0;
         rx_data  = 8'($urandom);
      end
   endtask

   task automatic send_q(input logic [7:0] q[$], input bit gaps);
      foreach (q[i]) begin
         if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         send(q[i]);
      end
   endtask

   task automatic settle();
      idle(2);
      #2;
   endtask

   task automatic full_frame();
      logic [7:0] q[$];
      q.push_back(8'hA5);
      q.push_back(8'd32);
      for (int i = 0; i < 32; i++) q.push_back(8'(i));
      q.push_back(8'h10);
      send_q(q, 1'b0);
   endtask

   int w0, d0;

   initial begin
      rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
      #2;
      check("reset_rdy", 32'(rx_ready_o), 0);
      check("reset_cpu", 32'(cpu_rst_o), 1);
      check("reset_we",  32'(mem_we_o), 0);
      check("reset_addr", 32'(mem_addr_o), 0);
      check("reset_data", 32'(mem_data_o), 0);
      check("reset_busy_done_err", {29'd0, busy_o, done_o, err_o}, 0);
      #21 rst = 1'b0;
      idle(3);

      // Basic good frame.
      w0 = wr_cnt; d0 = done_cnt;
      send_q('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9A}, 1'b0);
      settle();
      check("good_writes", wr_cnt - w0, 3);
      check("good_mem0", 32'(shadow[0]), 32'h11);
      check("good_mem1", 32'(shadow[1]), 32'h22);
      check("good_mem2", 32'(shadow[2]), 32'h33);
      check("good_done", done_cnt - d0, 1);
      check("good_cpu_rst", 32'(cpu_rst_o), 0);
      check("good_err", 32'(err_o), 0);

      // Bad checksum, then recovery.
      w0 = wr_cnt; d0 = done_cnt;
      send_q('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9B}, 1'b0);
      settle();
      check("badck_writes", wr_cnt - w0, 3);
      check("badck_err", 32'(err_o), 1);
      check("badck_cpu_rst", 32'(cpu_rst_o), 1);
      check("badck_done", done_cnt - d0, 0);
      send(8'hA5);
      @(posedge clk); #1;
      check("sync_clears_err", 32'(err_o), 0);
      check("sync_busy", 32'(busy_o), 1);
      d0 = done_cnt;
      send_q('{8'h01, 8'h44, 8'hBC}, 1'b0);
      settle();
      check("recover_done", done_cnt - d0, 1);
      check("recover_cpu_rst", 32'(cpu_rst_o), 0);

      // Illegal lengths.
      for (int k = 0; k < 2; k++) begin
         logic [7:0] bad_len;
         bad_len = (k == 0) ? 8'h00 : 8'h21;
         w0 = wr_cnt; d0 = done_cnt;
         send_q('{8'hA5, bad_len}, 1'b0);
         settle();
         check("badlen_err", 32'(err_o), 1);
         check("badlen_writes", wr_cnt - w0, 0);
         check("badlen_busy", 32'(busy_o), 0);
         send_q('{8'hA5, 8'h01, 8'h44, 8'hBC}, 1'b0);
         settle();
         check("badlen_resync_done", done_cnt - d0, 1);
      end

      // Full-depth frame.
      w0 = wr_cnt; d0 = done_cnt;
      full_frame();
      settle();
      check("full_writes", wr_cnt - w0, 32);
      check("full_mem16", 32'(shadow[16]), 32'h10);
      check("full_mem31", 32'(shadow[31]), 32'h1F);
      check("full_done", done_cnt - d0, 1);

      // Timeout fires exactly TO cycles after the last accepted byte.
      send_q('{8'hA5, 8'h02, 8'h11}, 1'b0);
      idle(TO + 5);
      #2;
      check("timeout_err", 32'(err_o), 1);
      check("timeout_delay", err_rise - last_acc, 1000);
      check("timeout_cpu_rst", 32'(cpu_rst_o), 1);
      check("timeout_busy", 32'(busy_o), 0);

      // Bytes at TO-1 and at TO idle cycles both arrive in time.
      d0 = done_cnt;
      send_q('{8'hA5, 8'h02, 8'h11}, 1'b0);
      idle(TO - 2);
      send(8'h22);
      idle(TO - 1);
      send(8'hCD);
      settle();
      check("late_byte_done", done_cnt - d0, 1);
      check("late_byte_err", 32'(err_o), 0);

      // Asynchronous reset mid-payload.
      send_q('{8'hA5, 8'h05, 8'h01, 8'h02}, 1'b0);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("arst_we", 32'(mem_we_o), 0);
      check("arst_cpu", 32'(cpu_rst_o), 1);
      check("arst_busy", 32'(busy_o), 0);
      check("arst_rdy", 32'(rx_ready_o), 0);
      check("arst_addr", 32'(mem_addr_o), 0);
      w0 = wr_cnt;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle(2);
      #2;
      check("arst_no_write", wr_cnt - w0, 0);
      w0 = wr_cnt; d0 = done_cnt;
      full_frame();
      settle();
      check("arst_reload_writes", wr_cnt - w0, 32);
      check("arst_reload_done", done_cnt - d0, 1);

      // Randomized traffic: junk, good frames, bad checksums, bad lengths, small gaps.
      for (int it = 0; it < 60; it++) begin
         logic [7:0] q[$];
         int kind, len, sum;
         kind = $urandom_range(0, 3);
         q = {};
         if (kind == 0) begin
            for (int j = 0; j < int'($urandom_range(1, 4)); j++) begin
               logic [7:0] b;
               b = 8'($urandom);
               if (b == 8'hA5) b = 8'h5A;
               q.push_back(b);
            end
         end else if (kind == 3) begin
            q.push_back(8'hA5);
            q.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(33, 255)));
         end else begin
            len = $urandom_range(1, 32);
            sum = 0;
            q.push_back(8'hA5);
            q.push_back(8'(len));
            for (int j = 0; j < len; j++) begin
               logic [7:0] b;
               b = 8'($urandom);
               sum += int'(b);
               q.push_back(b);
            end
            q.push_back(8'(256 - (sum % 256)) ^ ((kind == 2) ? 8'h01 : 8'h00));
         end
         send_q(q, 1'b1);
         if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 4));
      end
      settle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
